// File: rtl/core_pkg.sv
// Shared definitions for the 16-bit pipelined core: widths, opcodes,
// memory-stage FSM states and the memory-op decode helper.
package core_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 16;
  localparam int CTRL_W = 5;
  localparam int IDX_W  = 5;

  // Opcodes occupy control[3:0]
  localparam logic [3:0] OP_NOP    = 4'b0000;
  localparam logic [3:0] OP_SUB    = 4'b0001;
  localparam logic [3:0] OP_ADD    = 4'b0010;
  localparam logic [3:0] OP_ADDI   = 4'b0011;
  localparam logic [3:0] OP_SHLLI  = 4'b0100;
  localparam logic [3:0] OP_SHRLI  = 4'b0101;
  localparam logic [3:0] OP_JUMP   = 4'b0110;
  localparam logic [3:0] OP_JUMPL  = 4'b0111;
  localparam logic [3:0] OP_JUMPG  = 4'b1000;
  localparam logic [3:0] OP_JUMPE  = 4'b1001;
  localparam logic [3:0] OP_JUMPNE = 4'b1010;
  localparam logic [3:0] OP_CMP    = 4'b1011;
  localparam logic [3:0] OP_LOAD   = 4'b1100;
  localparam logic [3:0] OP_LOADI  = 4'b1101;
  localparam logic [3:0] OP_STORE  = 4'b1110;
  localparam logic [3:0] OP_MOV    = 4'b1111;

  // Control word written into the writeback latch for a bubble
  localparam logic [CTRL_W-1:0] CTRL_NOP = '0;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_state_t;

  // Only LOAD and STORE touch data memory; LOADI is an immediate move
  function automatic logic is_mem_op(input logic [3:0] op);
    return (op == OP_LOAD) || (op == OP_STORE);
  endfunction

endpackage

// File: rtl/mem_handshake.sv
// Data-memory request/ack handshake: IDLE/WAIT FSM, held request
// registers, timeout counter and sticky timeout error flag.
//
// Handshake: mem_req rises on the edge after issue and stays high, with
// mem_we/mem_addr/mem_wdata frozen, until the edge following the cycle
// in which mem_ack is sampled high (one-cycle pulse) or the access times
// out. mem_ack is only meaningful in WAIT; it is ignored in IDLE.
module mem_handshake
  import core_pkg::*;
#(
  parameter int ADDR_W  = core_pkg::ADDR_W,
  parameter int DATA_W  = core_pkg::DATA_W,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              issue,
  input  logic              issue_we,
  input  logic [ADDR_W-1:0] issue_addr,
  input  logic [DATA_W-1:0] issue_wdata,
  input  logic              mem_ack,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_err,
  output mem_state_t        state,
  output logic              complete,
  output logic              expire
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  mem_state_t       state_next;
  logic [CNT_W-1:0] cnt;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state: issue moves to WAIT; ack or timeout returns to IDLE
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (issue) state_next = WAIT;
      WAIT:    if (complete || expire) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM outputs: ack wins over a coincident timeout
  always_comb begin
    complete = 1'b0;
    expire   = 1'b0;
    if (state == WAIT) begin
      complete = mem_ack;
      expire   = !mem_ack && (cnt == CNT_LAST);
    end
  end

  // Request registers and wait counter
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cnt       <= '0;
    end else if (state == IDLE && issue) begin
      mem_req   <= 1'b1;
      mem_we    <= issue_we;
      mem_addr  <= issue_addr;
      mem_wdata <= issue_wdata;
      cnt       <= '0;
    end else if (complete || expire) begin
      mem_req   <= 1'b0;
    end else if (state == WAIT) begin
      cnt       <= cnt + CNT_W'(1);
    end
  end

  // Sticky timeout flag, cleared only by reset
  always_ff @(posedge clk) begin
    if (reset)       mem_err <= 1'b0;
    else if (expire) mem_err <= 1'b1;
  end

endmodule

// File: rtl/mem_stage.sv
// Memory stage: decodes memory ops, stalls upstream while an access is
// outstanding and drives the registered writeback latch.
module mem_stage
  import core_pkg::*;
#(
  parameter int ADDR_W  = core_pkg::ADDR_W,
  parameter int DATA_W  = core_pkg::DATA_W,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [4:0]        control_in,
  input  logic [DATA_W-1:0] result_in,
  input  logic [DATA_W-1:0] store_data_in,
  input  logic [4:0]        dest_index_in,
  input  logic              dest_we_in,
  output logic              stall_out,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [DATA_W-1:0] wb_data,
  output logic [4:0]        wb_dest,
  output logic              wb_we,
  output logic [4:0]        wb_control,
  output logic              mem_err
);

  mem_state_t state;
  logic       is_mem;
  logic       issue;
  logic       complete;
  logic       expire;

  assign is_mem = is_mem_op(control_in[3:0]);
  assign issue  = (state == IDLE) && is_mem;

  mem_handshake #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .TIMEOUT (TIMEOUT)
  ) u_handshake (
    .clk         (clk),
    .reset       (reset),
    .issue       (issue),
    .issue_we    (control_in[3:0] == OP_STORE),
    .issue_addr  (ADDR_W'(result_in)),
    .issue_wdata (store_data_in),
    .mem_ack     (mem_ack),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_err     (mem_err),
    .state       (state),
    .complete    (complete),
    .expire      (expire)
  );

  // Stall mux: hold upstream on issue and while waiting; release on ack or timeout
  always_comb begin
    stall_out = 1'b0;
    if (state == IDLE) stall_out = is_mem;
    else               stall_out = !complete && !expire;
  end

  // Writeback latch: pass-through, memory completion, or bubble
  always_ff @(posedge clk) begin
    if (reset) begin
      wb_data    <= '0;
      wb_dest    <= '0;
      wb_we      <= 1'b0;
      wb_control <= CTRL_NOP;
    end else if (state == IDLE && !is_mem) begin
      wb_data    <= result_in;
      wb_dest    <= dest_index_in;
      wb_we      <= dest_we_in;
      wb_control <= control_in;
    end else if (complete) begin
      // Upstream has held its latch, so control_in/dest still describe the access
      wb_dest    <= dest_index_in;
      wb_control <= control_in;
      wb_data    <= mem_we ? result_in : mem_rdata;
      wb_we      <= !mem_we;
    end else begin
      wb_we      <= 1'b0;
      wb_control <= CTRL_NOP;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed testbench for mem_stage with hand-computed expectations.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  control_in;
  logic [15:0] result_in;
  logic [15:0] store_data_in;
  logic [4:0]  dest_index_in;
  logic        dest_we_in;
  logic        stall_out;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_ack;
  logic [15:0] wb_data;
  logic [4:0]  wb_dest;
  logic        wb_we;
  logic [4:0]  wb_control;
  logic        mem_err;

  localparam logic [4:0] C_NOP   = 5'h00;
  localparam logic [4:0] C_ADD   = 5'h02;
  localparam logic [4:0] C_LOAD  = 5'h0C;
  localparam logic [4:0] C_STORE = 5'h0E;

  int n_checks = 0;
  int n_pass   = 0;

  mem_stage #(.ADDR_W(16), .DATA_W(16), .TIMEOUT(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .control_in    (control_in),
    .result_in     (result_in),
    .store_data_in (store_data_in),
    .dest_index_in (dest_index_in),
    .dest_we_in    (dest_we_in),
    .stall_out     (stall_out),
    .mem_req       (mem_req),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_rdata     (mem_rdata),
    .mem_ack       (mem_ack),
    .wb_data       (wb_data),
    .wb_dest       (wb_dest),
    .wb_we         (wb_we),
    .wb_control    (wb_control),
    .mem_err       (mem_err)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Advance one edge; inputs are changed and outputs sampled 1ns after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [4:0] ctl, input logic [15:0] res,
                       input logic [15:0] sd, input logic [4:0] dst, input logic we);
    control_in    = ctl;
    result_in     = res;
    store_data_in = sd;
    dest_index_in = dst;
    dest_we_in    = we;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    reset     = 1'b1;
    mem_ack   = 1'b0;
    mem_rdata = 16'h0000;
    drive(C_NOP, 16'h0, 16'h0, 5'd0, 1'b0);
    tick();
    tick();
    // Reset values
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_wb_we", wb_we, 0);
    check("rst_wb_control", wb_control, 0);
    check("rst_wb_data", wb_data, 0);
    check("rst_mem_err", mem_err, 0);
    reset = 1'b0;

    // ADD pass-through
    drive(C_ADD, 16'h1234, 16'h0, 5'd3, 1'b1);
    settle();
    check("add_stall", stall_out, 0);
    tick();
    drive(C_NOP, 16'h0, 16'h0, 5'd0, 1'b0);
    check("add_wb_data", wb_data, 16'h1234);
    check("add_wb_dest", wb_dest, 3);
    check("add_wb_we", wb_we, 1);
    check("add_wb_control", wb_control, C_ADD);
    check("add_no_req", mem_req, 0);

    // LOAD with ack in the third WAIT cycle
    drive(C_LOAD, 16'h0040, 16'h0, 5'd5, 1'b1);
    settle();
    check("ld_issue_stall", stall_out, 1);
    for (int i = 0; i < 2; i++) begin
      tick();
      check("ld_wait_req", mem_req, 1);
      check("ld_wait_addr", mem_addr, 16'h0040);
      check("ld_wait_we", mem_we, 0);
      check("ld_wait_stall", stall_out, 1);
      check("ld_bubble_we", wb_we, 0);
      check("ld_bubble_ctl", wb_control, C_NOP);
    end
    tick();
    check("ld_ack_req", mem_req, 1);
    mem_ack   = 1'b1;
    mem_rdata = 16'hBEEF;
    settle();
    check("ld_ack_stall", stall_out, 0);
    tick();
    mem_ack = 1'b0;
    drive(C_NOP, 16'h0, 16'h0, 5'd0, 1'b0);
    check("ld_wb_data", wb_data, 16'hBEEF);
    check("ld_wb_we", wb_we, 1);
    check("ld_wb_dest", wb_dest, 5);
    check("ld_wb_control", wb_control, C_LOAD);
    check("ld_req_drop", mem_req, 0);

    // STORE with ack in the first WAIT cycle
    drive(C_STORE, 16'h0010, 16'h00AA, 5'd7, 1'b0);
    settle();
    check("st_issue_stall", stall_out, 1);
    tick();
    check("st_req", mem_req, 1);
    check("st_we", mem_we, 1);
    check("st_addr", mem_addr, 16'h0010);
    check("st_wdata", mem_wdata, 16'h00AA);
    mem_ack = 1'b1;
    settle();
    check("st_ack_stall", stall_out, 0);
    tick();
    mem_ack = 1'b0;
    drive(C_NOP, 16'h0, 16'h0, 5'd0, 1'b0);
    check("st_wb_we", wb_we, 0);
    check("st_wb_control", wb_control, C_STORE);
    check("st_wb_data", wb_data, 16'h0010);
    check("st_req_drop", mem_req, 0);
    settle();
    check("st_idle_stall", stall_out, 0);

    // Timeout after 4 WAIT cycles, no ack
    drive(C_LOAD, 16'h0080, 16'h0, 5'd4, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("to_wait_req", mem_req, 1);
      check("to_wait_stall", stall_out, 1);
    end
    tick();
    check("to_last_req", mem_req, 1);
    check("to_last_stall", stall_out, 0);
    check("to_last_err", mem_err, 0);
    tick();
    drive(C_ADD, 16'h5555, 16'h0, 5'd9, 1'b1);
    check("to_req_drop", mem_req, 0);
    check("to_err_set", mem_err, 1);
    check("to_bubble_we", wb_we, 0);
    check("to_bubble_ctl", wb_control, C_NOP);
    settle();
    check("to_add_stall", stall_out, 0);
    tick();
    drive(C_NOP, 16'h0, 16'h0, 5'd0, 1'b0);
    check("to_add_wb_data", wb_data, 16'h5555);
    check("to_add_wb_we", wb_we, 1);
    check("to_add_wb_dest", wb_dest, 9);
    check("to_err_sticky", mem_err, 1);

    // Reset clears the sticky error
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst2_mem_err", mem_err, 0);

    // Ack coincident with the last timeout cycle: ack wins
    drive(C_LOAD, 16'h0020, 16'h0, 5'd6, 1'b1);
    for (int i = 0; i < 4; i++) tick();
    mem_ack   = 1'b1;
    mem_rdata = 16'h1357;
    settle();
    check("race_stall", stall_out, 0);
    tick();
    mem_ack = 1'b0;
    drive(C_NOP, 16'h0, 16'h0, 5'd0, 1'b0);
    check("race_wb_data", wb_data, 16'h1357);
    check("race_wb_we", wb_we, 1);
    check("race_mem_err", mem_err, 0);
    check("race_req_drop", mem_req, 0);

    // Reset in the second WAIT cycle, then a late ack
    drive(C_LOAD, 16'h0030, 16'h0, 5'd2, 1'b1);
    tick();
    tick();
    check("rw_req_before", mem_req, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    drive(C_NOP, 16'h0, 16'h0, 5'd0, 1'b0);
    mem_ack   = 1'b1;
    mem_rdata = 16'hFFFF;
    settle();
    check("rw_req", mem_req, 0);
    check("rw_addr", mem_addr, 0);
    check("rw_wb_we", wb_we, 0);
    check("rw_wb_data", wb_data, 0);
    check("rw_stall", stall_out, 0);
    tick();
    mem_ack = 1'b0;
    check("rw_late_wb_we", wb_we, 0);
    check("rw_late_wb_data", wb_data, 0);
    check("rw_late_wb_ctl", wb_control, C_NOP);
    check("rw_late_req", mem_req, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
